// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: holds operand matrices A and B and streams them,
// diagonally skewed and zero padded, into the edges of an N x N array.
module systolic_input_feeder #(
  parameter int N      = 3,
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  input  logic                  LOAD_SEL,
  input  logic [$clog2(N)-1:0]  LOAD_IDX,
  input  logic [N*DATA_W-1:0]   LOAD_DATA,
  input  logic                  START,
  output logic [N*DATA_W-1:0]   A_EDGE,
  output logic [N*DATA_W-1:0]   B_EDGE,
  output logic                  PERFORM_NEXT_OPERATION,
  output logic                  BUSY,
  output logic                  DONE
);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2*N);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FEED    = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;
  localparam logic [1:0] DONE_ST = 2'd3;

  localparam logic [TW-1:0] FEED_LAST  = TW'(2*N-2);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(N-2);

  logic [1:0]          state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [DATA_W-1:0]   a_q [N][N];
  logic [DATA_W-1:0]   a_d [N][N];
  logic [DATA_W-1:0]   b_q [N][N];
  logic [DATA_W-1:0]   b_d [N][N];
  logic [N*DATA_W-1:0] a_edge_q, a_edge_d;
  logic [N*DATA_W-1:0] b_edge_q, b_edge_d;
  logic                pno_q, pno_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_en;

  assign wr_en = LOAD_VALID && (state_q == IDLE);

  always_comb begin : next_state
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FEED;
          t_d     = '0;
        end
      end
      FEED: begin
        if (t_q == FEED_LAST) begin
          state_d = FLUSH;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      FLUSH: begin
        if (t_q == FLUSH_LAST) begin
          state_d = DONE_ST;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Rows with an index outside 0..N-1 match no entry and are dropped.
  always_comb begin : storage
    a_d = a_q;
    b_d = b_q;
    for (int r = 0; r < N; r++) begin
      if (wr_en && LOAD_IDX == IW'(r)) begin
        for (int k = 0; k < N; k++) begin
          if (LOAD_SEL) b_d[r][k] = LOAD_DATA[k*DATA_W +: DATA_W];
          else          a_d[r][k] = LOAD_DATA[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Outputs are decoded from next state so they leave on flops.
  always_comb begin : edges
    a_edge_d = '0;
    b_edge_d = '0;
    if (state_d == FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_d == TW'(i + k)) begin
            a_edge_d[i*DATA_W +: DATA_W] = a_d[i][k];
            b_edge_d[i*DATA_W +: DATA_W] = b_d[k][i];
          end
        end
      end
    end
    pno_d  = (state_d == FEED) || (state_d == FLUSH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE_ST);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= IDLE;
      t_q      <= '0;
      a_edge_q <= '0;
      b_edge_q <= '0;
      pno_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          a_q[r][k] <= '0;
          b_q[r][k] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      a_edge_q <= a_edge_d;
      b_edge_q <= b_edge_d;
      pno_q    <= pno_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign LOAD_READY             = (state_q == IDLE);
  assign A_EDGE                 = a_edge_q;
  assign B_EDGE                 = b_edge_q;
  assign PERFORM_NEXT_OPERATION = pno_q;
  assign BUSY                   = busy_q;
  assign DONE                   = done_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb_systolic_input_feeder: cycle model of the feed sequence plus
// directed skew, busy, reset and back-to-back vectors.
module tb_systolic_input_feeder;
  localparam int N = 3;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         LOAD_VALID;
  logic         LOAD_READY;
  logic         LOAD_SEL;
  logic [1:0]   LOAD_IDX;
  logic [N*W-1:0] LOAD_DATA;
  logic         START;
  logic [N*W-1:0] A_EDGE;
  logic [N*W-1:0] B_EDGE;
  logic         PNO;
  logic         BUSY;
  logic         DONE;

  int n_chk    = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  // Model: p = cycles since START (-1 when idle), plus matrix copies.
  int p = -1;
  int ma [N][N];
  int mb [N][N];

  always #5 CLK = ~CLK;

  systolic_input_feeder #(.N(N), .DATA_W(W)) dut (
    .CLK                    (CLK),
    .RESET                  (RESET),
    .LOAD_VALID             (LOAD_VALID),
    .LOAD_READY             (LOAD_READY),
    .LOAD_SEL               (LOAD_SEL),
    .LOAD_IDX               (LOAD_IDX),
    .LOAD_DATA              (LOAD_DATA),
    .START                  (START),
    .A_EDGE                 (A_EDGE),
    .B_EDGE                 (B_EDGE),
    .PERFORM_NEXT_OPERATION (PNO),
    .BUSY                   (BUSY),
    .DONE                   (DONE)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RESET) begin
      p <= -1;
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++) begin
          ma[r][k] <= 0;
          mb[r][k] <= 0;
        end
    end else if (p < 0) begin
      if (LOAD_VALID && LOAD_IDX < N)
        for (int k = 0; k < N; k++) begin
          if (LOAD_SEL) mb[LOAD_IDX][k] <= int'(LOAD_DATA[k*W +: W]);
          else          ma[LOAD_IDX][k] <= int'(LOAD_DATA[k*W +: W]);
        end
      if (START) p <= 0;
    end else begin
      p <= (p == 3*N-2) ? -1 : p + 1;
    end
  end

  function automatic logic [N*W-1:0] exp_edge(input bit is_b);
    logic [N*W-1:0] v = '0;
    if (p >= 0 && p <= 2*N-2)
      for (int i = 0; i < N; i++)
        if (p - i >= 0 && p - i < N)
          v[i*W +: W] = is_b ? W'(mb[p-i][i]) : W'(ma[i][p-i]);
    return v;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("a_edge", A_EDGE, exp_edge(1'b0));
      check("b_edge", B_EDGE, exp_edge(1'b1));
      check("pno", PNO, (p >= 0 && p < 3*N-2));
      check("busy", BUSY, (p >= 0));
      check("done", DONE, (p == 3*N-2));
      check("load_ready", LOAD_READY, (p < 0));
      if (DONE) done_cnt++;
    end
  end

  function automatic logic [N*W-1:0] pk(input int a, input int b,
                                        input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic load(input bit sel, input int idx, input int e0,
                      input int e1, input int e2);
    LOAD_VALID = 1'b1;
    LOAD_SEL   = sel;
    LOAD_IDX   = 2'(idx);
    LOAD_DATA  = pk(e0, e1, e2);
    step();
    LOAD_VALID = 1'b0;
  endtask

  task automatic load_ref();
    load(0, 0, 1, 2, 3);
    load(0, 1, 4, 5, 6);
    load(0, 2, 7, 8, 9);
    load(1, 0, 10, 11, 12);
    load(1, 1, 13, 14, 15);
    load(1, 2, 16, 17, 18);
  endtask

  task automatic run(output int lat, output int pn,
                     output logic [N*W-1:0] acc);
    START = 1'b1;
    step();
    START = 1'b0;
    lat = 1;
    pn  = 0;
    acc = '0;
    while (!DONE && lat < 4*N) begin
      if (PNO) pn++;
      acc = acc | A_EDGE | B_EDGE;
      step();
      lat++;
    end
  endtask

  task automatic skew_run(input bit inject);
    logic [N*W-1:0] ea [5];
    logic [N*W-1:0] eb [5];
    int d0;
    ea = '{pk(1,0,0), pk(2,4,0), pk(3,5,7), pk(0,6,8), pk(0,0,9)};
    eb = '{pk(10,0,0), pk(13,11,0), pk(16,14,12), pk(0,17,15),
           pk(0,0,18)};
    d0 = done_cnt;
    START = 1'b1;
    step();
    START = 1'b0;
    for (int c = 0; c < 2*N-1; c++) begin
      check("skew_a", A_EDGE, ea[c]);
      check("skew_b", B_EDGE, eb[c]);
      if (inject && c == 1) begin
        check("busy_ready", LOAD_READY, 1'b0);
        LOAD_VALID = 1'b1;
        LOAD_SEL   = 1'b0;
        LOAD_IDX   = 2'd0;
        LOAD_DATA  = pk(99, 99, 99);
        START      = 1'b1;
      end
      step();
      LOAD_VALID = 1'b0;
      START      = 1'b0;
    end
    for (int c = 0; c < N-1; c++) begin
      check("flush_edges", A_EDGE | B_EDGE, '0);
      check("flush_pno", PNO, 1'b1);
      step();
    end
    check("skew_done", DONE, 1'b1);
    step();
    check("skew_idle", BUSY, 1'b0);
    check("skew_one_done", done_cnt - d0, 1);
  endtask

  initial begin
    int lat, pn, lat2, pn2, t1, t2;
    logic [N*W-1:0] acc;

    RESET      = 1'b0;
    START      = 1'b1;
    LOAD_VALID = 1'b1;
    LOAD_SEL   = 1'b0;
    LOAD_IDX   = 2'd0;
    LOAD_DATA  = pk(42, 43, 44);
    step();
    chk_en = 1'b1;
    step();
    step();
    check("rst_a_edge", A_EDGE, '0);
    check("rst_b_edge", B_EDGE, '0);
    check("rst_pno", PNO, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_ready", LOAD_READY, 1'b1);
    RESET      = 1'b1;
    START      = 1'b0;
    LOAD_VALID = 1'b0;
    step();

    run(lat, pn, acc);
    check("rst_no_write", acc, '0);
    step();

    load_ref();
    load(0, 3, 77, 77, 77);
    skew_run(1'b0);
    skew_run(1'b1);
    skew_run(1'b0);

    LOAD_VALID = 1'b1;
    LOAD_SEL   = 1'b0;
    LOAD_IDX   = 2'd0;
    LOAD_DATA  = pk(5, 6, 7);
    START      = 1'b1;
    step();
    LOAD_VALID = 1'b0;
    START      = 1'b0;
    check("simul_a", A_EDGE, pk(5, 0, 0));
    check("simul_b", B_EDGE, pk(10, 0, 0));
    lat = 0;
    while (BUSY && lat < 4*N) begin
      step();
      lat++;
    end
    check("simul_finish", BUSY, 1'b0);

    START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    t1 = done_cnt;
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    check("mid_rst_pno", PNO, 1'b0);
    check("mid_rst_edges", A_EDGE | B_EDGE, '0);
    check("mid_rst_busy", BUSY, 1'b0);
    repeat (3*N) step();
    check("mid_rst_no_done", done_cnt - t1, 0);
    run(lat, pn, acc);
    check("zero_lat", lat, 3*N-1);
    check("zero_pno_len", pn, 3*N-2);
    check("zero_stream", acc, '0);
    step();

    load_ref();
    run(lat, pn, acc);
    t1 = cyc;
    step();
    run(lat2, pn2, acc);
    t2 = cyc;
    check("b2b_pno1", pn, 3*N-2);
    check("b2b_pno2", pn2, 3*N-2);
    check("b2b_lat2", lat2, 3*N-1);
    check("b2b_spacing", t2 - t1, 3*N);
    step();
    check("b2b_idle", BUSY, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

Upstream feeder for the N×N systolic multiply array built from square processing elements. It holds matrices A and B, loaded one row per handshake. On START it drives the array's left edge (A rows) and top edge (B columns) with diagonally skewed, zero-padded operand streams. It holds PERFORM_NEXT_OPERATION high for exactly the cycles the array needs to finish every product, then pulses DONE.

## Interface
- N, 3, array dimension (rows = columns = N, N ≥ 2)
- DATA_W, 8, element width in bits
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-low reset
- LOAD_VALID  in  1  row-write request
- LOAD_READY  out  1  row-write accepted when high with LOAD_VALID
- LOAD_SEL  in  1  0 = write matrix A, 1 = write matrix B
- LOAD_IDX  in  $clog2(N)  row index written
- LOAD_DATA  in  N*DATA_W  row contents; element k at bits [k*DATA_W +: DATA_W]
- START  in  1  begin a feed sequence (sampled in IDLE only)
- A_EDGE  out  N*DATA_W  lane i → left-edge Axy input of array row i
- B_EDGE  out  N*DATA_W  lane j → top-edge Bxy input of array column j
- PERFORM_NEXT_OPERATION  out  1  array step enable
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- Storage: two N×N register arrays, A and B, cleared to 0 by reset. A row write occurs on any edge with LOAD_VALID & LOAD_READY. The write sets A[LOAD_IDX][*] or B[LOAD_IDX][*] to LOAD_DATA. LOAD_IDX ≥ N means the write is dropped.
- LOAD_READY = ~BUSY.
- States are IDLE, FEED, FLUSH and DONE_ST.
- IDLE: BUSY=0, PNO=0, edges=0. START=1 moves to FEED with t=0.
- FEED: lasts 2N-1 cycles, t = 0..2N-2.
  - Lane i of A_EDGE = A[i][t-i] if 0 ≤ t-i < N, else 0.
  - Lane j of B_EDGE = B[t-j][j] if 0 ≤ t-j < N, else 0.
  - PNO=1 throughout.
- FLUSH: lasts N-1 cycles. Edges = 0, PNO=1. This lets the last operands propagate to PE(N-1,N-1).
- DONE_ST: lasts 1 cycle. DONE=1, PNO=0, edges=0, BUSY=1. Next state is IDLE.
- BUSY=1 in FEED, FLUSH and DONE_ST.
- START outside IDLE is ignored. It is not queued.
- LOAD_VALID while BUSY: no write and no side effect. The stored matrices stay constant for the whole sequence.
- LOAD_VALID and START on the same IDLE edge: the write commits, and the feed uses the updated matrix.
- All outputs are registered. No combinational path from any input to any output except LOAD_READY, which depends only on state.
- The edge values are copied unchanged. No arithmetic is performed and width is DATA_W end to end.

## Timing
- Reset (RESET=0 at an edge) gives IDLE, all outputs 0 except LOAD_READY=1, and A=B=0. Reset overrides everything, including mid-FEED or mid-FLUSH. PNO drops on the next edge and no DONE is issued.
- START high at edge k (in IDLE) produces the first FEED cycle (t=0) as registered outputs after edge k. BUSY=1 and LOAD_READY=0 from that point.
- PNO is high for exactly 3N-2 consecutive cycles (7 for N=3).
- DONE is high in the cycle immediately after the last PNO cycle. IDLE follows one cycle later.
- START latency to DONE is 3N-1 cycles.
- The earliest restart is a START sampled in the first IDLE cycle after DONE.

## Test plan
- Reset: hold RESET=0 for 3 cycles while START=1 and LOAD_VALID=1. Required: all outputs 0, LOAD_READY=1, no write performed (a later feed streams only zeros).
- Skew, N=3:
  - Load A rows {1,2,3}, {4,5,6}, {7,8,9} and B rows {10,11,12}, {13,14,15}, {16,17,18}, then START.
  - A lanes per cycle: (1,0,0), (2,4,0), (3,5,7), (0,6,8), (0,0,9).
  - B lanes per cycle: (10,0,0), (13,11,0), (16,14,12), (0,17,15), (0,0,18).
  - Then 2 zero cycles with PNO=1, then DONE for 1 cycle.
- Busy protection: during FEED, attempt LOAD_VALID with A row 0 = {99,99,99}, and pulse START. Required: LOAD_READY=0, the stream is unchanged, exactly one DONE, and a second run reproduces the original values.
- Simultaneous load+start: in IDLE, write A row 0 = {5,6,7} on the same edge as START. Required: first-cycle A lane0 = 5.
- Mid-operation reset: assert RESET=0 at FEED t=2. Required: next cycle PNO=0 with all edges 0, and no DONE. A following START with no loads streams only zeros and completes in 3N-1 cycles.
- Back-to-back: START in the first IDLE cycle after DONE. Required: a second identical 7-cycle PNO window, and DONE pulses spaced exactly 3N cycles apart (9 for N=3).
